// File: rtl/sd_dat_rx.sv
// -----------------------------------------------------------------------------
// sd_dat_rx
//   Receives one SD-card data block on a 4-bit DAT bus. It waits for the
//   all-zero start bit and assembles bytes (high nibble first). It checks a
//   per-line CRC16 (x^16+x^12+x^5+1, seed 0) and checks the end bit.
//
// Ports
//   sd_clk       : clock, all state on the rising edge
//   rst          : synchronous active-high reset
//   DAT_din[3:0] : DAT line samples, DAT[3] is the nibble MSB
//   rx_start     : start one block (accepted only in IDLE)
//   abort        : cancel reception, return to IDLE without done
//   block_size   : block length in bytes (latched on accepted rx_start)
//   timeout      : WAIT_START cycle limit, 0 = no limit (latched likewise)
//   data_out     : received byte, qualified by data_valid
//   data_valid   : one-cycle byte strobe
//   busy         : high in every state except IDLE
//   done         : one-cycle completion pulse
//   crc_err[3:0] : per-line CRC mismatch flags
//   end_err      : end bit was not 4'hF
//   timeout_err  : no start bit seen within timeout
// -----------------------------------------------------------------------------
module sd_dat_rx (
  input  logic        sd_clk,
  input  logic        rst,
  input  logic [3:0]  DAT_din,
  input  logic        rx_start,
  input  logic        abort,
  input  logic [11:0] block_size,
  input  logic [15:0] timeout,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        busy,
  output logic        done,
  output logic [3:0]  crc_err,
  output logic        end_err,
  output logic        timeout_err
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WAIT_START = 3'd1;
  localparam logic [2:0] DATA       = 3'd2;
  localparam logic [2:0] CRC        = 3'd3;
  localparam logic [2:0] END        = 3'd4;
  localparam logic [2:0] DONE       = 3'd5;

  logic [2:0]  state_reg;
  logic [11:0] byte_cnt_reg;
  logic [15:0] timeout_reg;
  logic [15:0] wait_cnt_reg;
  logic        low_nibble_reg;
  logic [3:0]  hi_nibble_reg;
  logic [3:0]  crc_cnt_reg;
  logic [7:0]  data_out_reg;
  logic        data_valid_reg;
  logic        done_reg;
  logic [3:0]  crc_err_reg;
  logic        end_err_reg;
  logic        timeout_err_reg;
  logic [3:0]  crc_mismatch;
  logic [16:0] wait_cnt_next;

  logic accept;
  assign accept = (state_reg == IDLE) && rx_start && !abort;

  // 17-bit so the comparison can never be defeated by wrap-around.
  assign wait_cnt_next = {1'b0, wait_cnt_reg} + 17'd1;

  // ---------------------------------------------------------------------------
  // Per-line CRC: one generator and one received-CRC shifter per DAT line.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_line
      logic [15:0] crc_calc_reg;
      logic [15:0] crc_rx_reg;
      logic        feedback;

      assign feedback = DAT_din[gi] ^ crc_calc_reg[15];

      always_ff @(posedge sd_clk) begin
        if (rst) begin
          crc_calc_reg <= 16'h0000;
          crc_rx_reg   <= 16'h0000;
        end else if (accept) begin
          crc_calc_reg <= 16'h0000;
        end else if (state_reg == DATA) begin
          crc_calc_reg <= {crc_calc_reg[14:0], 1'b0} ^ ({16{feedback}} & 16'h1021);
        end else if (state_reg == CRC) begin
          crc_rx_reg <= {crc_rx_reg[14:0], DAT_din[gi]};
        end
      end

      // Evaluated in the last CRC cycle, folding in the bit on the line now.
      assign crc_mismatch[gi] = ({crc_rx_reg[14:0], DAT_din[gi]} != crc_calc_reg);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Control FSM and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge sd_clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      byte_cnt_reg    <= 12'd0;
      timeout_reg     <= 16'd0;
      wait_cnt_reg    <= 16'd0;
      low_nibble_reg  <= 1'b0;
      hi_nibble_reg   <= 4'd0;
      crc_cnt_reg     <= 4'd0;
      data_out_reg    <= 8'd0;
      data_valid_reg  <= 1'b0;
      done_reg        <= 1'b0;
      crc_err_reg     <= 4'd0;
      end_err_reg     <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      data_valid_reg <= 1'b0;
      done_reg       <= 1'b0;
      if (abort) begin
        state_reg <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (rx_start) begin
              byte_cnt_reg    <= block_size;
              timeout_reg     <= timeout;
              // The acceptance cycle counts as the first waited cycle.
              wait_cnt_reg    <= 16'd1;
              low_nibble_reg  <= 1'b0;
              crc_cnt_reg     <= 4'd0;
              crc_err_reg     <= 4'd0;
              end_err_reg     <= 1'b0;
              timeout_err_reg <= 1'b0;
              state_reg       <= (block_size == 12'd0) ? DONE : WAIT_START;
            end
          end
          WAIT_START: begin
            if (DAT_din == 4'b0000) begin
              state_reg <= DATA;
            end else begin
              wait_cnt_reg <= wait_cnt_next[15:0];
              if ((timeout_reg != 16'd0) && (wait_cnt_next >= {1'b0, timeout_reg})) begin
                timeout_err_reg <= 1'b1;
                state_reg       <= DONE;
              end
            end
          end
          DATA: begin
            if (!low_nibble_reg) begin
              hi_nibble_reg  <= DAT_din;
              low_nibble_reg <= 1'b1;
            end else begin
              low_nibble_reg <= 1'b0;
              data_out_reg   <= {hi_nibble_reg, DAT_din};
              data_valid_reg <= 1'b1;
              byte_cnt_reg   <= byte_cnt_reg - 12'd1;
              if (byte_cnt_reg == 12'd1) begin
                state_reg <= CRC;
              end
            end
          end
          CRC: begin
            crc_cnt_reg <= crc_cnt_reg + 4'd1;
            if (crc_cnt_reg == 4'd15) begin
              crc_err_reg <= crc_mismatch;
              state_reg   <= END;
            end
          end
          END: begin
            end_err_reg <= (DAT_din != 4'hF);
            state_reg   <= DONE;
          end
          DONE: begin
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign data_out    = data_out_reg;
  assign data_valid  = data_valid_reg;
  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;
  assign crc_err     = crc_err_reg;
  assign end_err     = end_err_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_sd_dat_rx.sv
// -----------------------------------------------------------------------------
// tb_sd_dat_rx
//   Self-checking bench for sd_dat_rx. Expected bytes are queued as nibbles
//   are driven and popped by a monitor when data_valid strobes. Each scenario
//   task checks done timing and the error flags inline.
// -----------------------------------------------------------------------------
module tb_sd_dat_rx;

  logic        sd_clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  DAT_din = 4'hF;
  logic        rx_start = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] block_size = 12'd0;
  logic [15:0] timeout = 16'd0;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        busy;
  logic        done;
  logic [3:0]  crc_err;
  logic        end_err;
  logic        timeout_err;

  sd_dat_rx dut (
    .sd_clk      (sd_clk),
    .rst         (rst),
    .DAT_din     (DAT_din),
    .rx_start    (rx_start),
    .abort       (abort),
    .block_size  (block_size),
    .timeout     (timeout),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .busy        (busy),
    .done        (done),
    .crc_err     (crc_err),
    .end_err     (end_err),
    .timeout_err (timeout_err)
  );

  always #5 sd_clk = ~sd_clk;

  int cyc = 0;
  always @(posedge sd_clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  logic [7:0] exp_q[$];
  logic [7:0] tx[$];

  // Scoreboard monitor: sampled mid-cycle.
  always @(negedge sd_clk) begin
    logic [7:0] e;
    if (data_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL data_unexpected got=%02h want=no strobe (cycle %0d)", data_out, cyc);
      end else begin
        e = exp_q.pop_front();
        if (data_out !== e) begin
          bad++;
          $display("FAIL data_byte got=%02h want=%02h (cycle %0d)", data_out, e, cyc);
        end else begin
          $display("rx byte %02h (cycle %0d)", data_out, cyc);
        end
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      $display("done (cycle %0d) crc_err=%b end_err=%b timeout_err=%b",
               cyc, crc_err, end_err, timeout_err);
    end
  end

  task automatic tick();
    @(posedge sd_clk);
    #1;
  endtask

  function automatic logic [15:0] crc16_bit(input logic [15:0] c, input logic b);
    logic [15:0] n;
    n = {c[14:0], 1'b0};
    if (b ^ c[15]) n = n ^ 16'h1021;
    return n;
  endfunction

  // rx_start high during cycle r; returns at cycle r+1.
  task automatic start_rx(input logic [11:0] sz, input logic [15:0] to, output int r);
    tick();
    r = cyc;
    block_size = sz;
    timeout = to;
    rx_start = 1'b1;
    tick();
    rx_start = 1'b0;
  endtask

  task automatic wait_done(input int prev, input int limit, input string name);
    for (int w = 0; w < limit && done_cnt == prev; w++) @(negedge sd_clk);
    total++;
    if (done_cnt == prev) begin
      bad++;
      $display("FAIL %s_done_seen got=none want=done within %0d cycles", name, limit);
    end
  endtask

  // Full block: optional idle/partial-start cycles, data, CRC (optionally
  // with one flipped bit), end nibble. Optionally pulses rx_start mid-DATA.
  task automatic run_block(input int nbytes, input int flip_line, input int flip_bit,
                           input logic [3:0] end_nib, input int pre_idle,
                           input bit mid_start, input string name);
    logic [15:0] crc [4];
    logic [3:0]  nib;
    logic [7:0]  v;
    int r, s, prev;
    prev = done_cnt;
    for (int i = 0; i < 4; i++) crc[i] = 16'h0000;
    start_rx(12'(nbytes), 16'd0, r);
    for (int k = 0; k < pre_idle; k++) begin
      DAT_din = (k % 2 == 0) ? 4'b0001 : 4'hF;
      tick();
    end
    DAT_din = 4'b0000;
    s = cyc;
    tick();
    for (int b = 0; b < nbytes; b++) begin
      v = tx[b];
      exp_q.push_back(v);
      for (int h = 0; h < 2; h++) begin
        nib = (h == 0) ? v[7:4] : v[3:0];
        DAT_din = nib;
        for (int i = 0; i < 4; i++) crc[i] = crc16_bit(crc[i], nib[i]);
        if (mid_start && b == 0 && h == 1) begin
          rx_start = 1'b1;
          block_size = 12'd1;
        end else begin
          rx_start = 1'b0;
        end
        tick();
      end
    end
    rx_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 4; i++) begin
        nib[i] = crc[i][15-k];
        if (i == flip_line && (15 - k) == flip_bit) nib[i] = ~nib[i];
      end
      DAT_din = nib;
      tick();
    end
    DAT_din = end_nib;
    tick();
    DAT_din = 4'hF;
    wait_done(prev, 10, name);
    total++;
    if (done_cyc != s + 2 * nbytes + 19) begin
      bad++;
      $display("FAIL %s_done_latency got=%0d want=%0d", name, done_cyc - s, 2 * nbytes + 19);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_bytes_missing got=%0d left want=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_flags(input string name, input logic [3:0] ce,
                             input logic ee, input logic te);
    total++;
    if ({crc_err, end_err, timeout_err} !== {ce, ee, te}) begin
      bad++;
      $display("FAIL %s_flags got crc=%b end=%b to=%b want crc=%b end=%b to=%b",
               name, crc_err, end_err, timeout_err, ce, ee, te);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_start = 1'b1;
    block_size = 12'd4;
    repeat (3) tick();
    @(negedge sd_clk);
    total++;
    if ({data_out, data_valid, busy, done, crc_err, end_err, timeout_err} !== 17'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0",
               {data_out, data_valid, busy, done, crc_err, end_err, timeout_err});
    end
    tick();
    rst = 1'b0;
    rx_start = 1'b0;
    tick();
  endtask

  task automatic test_zero_block();
    tx = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_block(4, -1, 0, 4'hF, 3, 1'b0, "zero_block");
    @(negedge sd_clk);
    check_flags("zero_block", 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_byte_order();
    tx = '{8'hA5, 8'h3C};
    run_block(2, -1, 0, 4'hF, 0, 1'b1, "byte_order");
    @(negedge sd_clk);
    check_flags("byte_order", 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_crc_fault();
    tx = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_block(4, 2, 7, 4'hF, 1, 1'b0, "crc_fault");
    @(negedge sd_clk);
    check_flags("crc_fault", 4'b0100, 1'b0, 1'b0);
    repeat (4) tick();
    @(negedge sd_clk);
    check_flags("crc_fault_hold", 4'b0100, 1'b0, 1'b0);
  endtask

  task automatic test_end_fault();
    tx = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_block(4, -1, 0, 4'h7, 0, 1'b0, "end_fault");
    @(negedge sd_clk);
    check_flags("end_fault", 4'b0000, 1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    int r, prev;
    prev = done_cnt;
    DAT_din = 4'hF;
    start_rx(12'd4, 16'd10, r);
    @(negedge sd_clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout_busy got=%b want=1", busy);
    end
    wait_done(prev, 20, "timeout");
    total++;
    if (done_cyc != r + 11) begin
      bad++;
      $display("FAIL timeout_latency got=%0d want=11", done_cyc - r);
    end
    check_flags("timeout", 4'b0000, 1'b0, 1'b1);
  endtask

  task automatic test_empty_block();
    int r, prev;
    prev = done_cnt;
    start_rx(12'd0, 16'd0, r);
    wait_done(prev, 5, "empty_block");
    total++;
    if (done_cyc != r + 2) begin
      bad++;
      $display("FAIL empty_block_latency got=%0d want=2", done_cyc - r);
    end
    check_flags("empty_block", 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    int r, prev;
    logic [7:0] v;
    prev = done_cnt;
    tx = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    start_rx(12'd8, 16'd0, r);
    DAT_din = 4'b0000;
    tick();
    for (int b = 0; b < 3; b++) begin
      v = tx[b];
      exp_q.push_back(v);
      DAT_din = v[7:4];
      tick();
      DAT_din = v[3:0];
      tick();
    end
    DAT_din = 4'h9;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge sd_clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_busy got=%b want=0", busy);
    end
    for (int k = 0; k < 30; k++) begin
      DAT_din = 4'(k);
      tick();
    end
    DAT_din = 4'hF;
    @(negedge sd_clk);
    total++;
    if (done_cnt != prev) begin
      bad++;
      $display("FAIL abort_no_done got=%0d dones want=0", done_cnt - prev);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL abort_bytes got=%0d left want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int r;
    tx = '{8'h5A, 8'hC3, 8'h81, 8'h7E};
    start_rx(12'd4, 16'd0, r);
    DAT_din = 4'b0000;
    tick();
    for (int b = 0; b < 2; b++) begin
      exp_q.push_back(tx[b]);
      DAT_din = tx[b][7:4];
      tick();
      DAT_din = tx[b][3:0];
      tick();
    end
    DAT_din = tx[2][7:4];
    rst = 1'b1;
    tick();
    @(negedge sd_clk);
    total++;
    if ({data_out, data_valid, busy, done, crc_err, end_err, timeout_err} !== 17'd0) begin
      bad++;
      $display("FAIL reset_mid_outputs got=%h want=0",
               {data_out, data_valid, busy, done, crc_err, end_err, timeout_err});
    end
    tick();
    rst = 1'b0;
    DAT_din = 4'hF;
    tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL reset_mid_bytes got=%0d left want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_zero_block();
    test_byte_order();
    test_crc_fault();
    test_end_fault();
    test_timeout();
    test_empty_block();
    test_abort();
    test_byte_order();
    test_reset_mid();
    test_zero_block();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
